// File: rtl/register_file_pkg.sv
// Shared constants for the RISC-V integer register file.
package register_file_pkg;

  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file_if.sv
// Bus bundle between the datapath (master) and the register file (slave):
// one write port plus two combinational read ports.
interface register_file_if #(
  parameter int WORDSIZE = register_file_pkg::XLEN
);
  import register_file_pkg::*;

  logic                  write_en;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [WORDSIZE-1:0]   write_data;
  logic [REG_ADDR_W-1:0] addr_a;
  logic [REG_ADDR_W-1:0] addr_b;
  logic [WORDSIZE-1:0]   data_a;
  logic [WORDSIZE-1:0]   data_b;

  modport master (
    output write_en, write_addr, write_data, addr_a, addr_b,
    input  data_a, data_b
  );

  modport slave (
    input  write_en, write_addr, write_data, addr_a, addr_b,
    output data_a, data_b
  );

endinterface

// File: rtl/register_file_read_mux.sv
// One combinational read port: selects a register by index, with index 0
// forced to zero so x0 never depends on what the storage holds.
module register_file_read_mux
  import register_file_pkg::*;
#(
  parameter int WORDSIZE = XLEN
) (
  input  logic [WORDSIZE-1:0]   regs_i [NUM_REGS],
  input  logic [REG_ADDR_W-1:0] addr_i,
  output logic [WORDSIZE-1:0]   data_o
);

  // Zero-latency select; x0 reads as zero regardless of storage
  always_comb begin
    data_o = '0;
    if (addr_i != ZERO_REG) begin
      data_o = regs_i[addr_i];
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x WORDSIZE integer register file: one synchronous write port, two
// combinational read ports, x0 hardwired to zero, async active-low clear.
// Reads see the stored array only, so a same-cycle write to the read
// address shows up just after the edge, never before it.
module register_file
  import register_file_pkg::*;
#(
  parameter int WORDSIZE = XLEN
) (
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave bus
);

  logic [WORDSIZE-1:0] regs_q [NUM_REGS];
  logic [WORDSIZE-1:0] regs_d [NUM_REGS];

  // Write decode: only the addressed entry changes, and never x0
  always_comb begin
    regs_d = regs_q;
    if (bus.write_en && (bus.write_addr != ZERO_REG)) begin
      regs_d[bus.write_addr] = bus.write_data;
    end
  end

  // Storage; reset clears every entry at once and blocks writes while low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  register_file_read_mux #(.WORDSIZE(WORDSIZE)) u_read_a (
    .regs_i (regs_q),
    .addr_i (bus.addr_a),
    .data_o (bus.data_a)
  );

  register_file_read_mux #(.WORDSIZE(WORDSIZE)) u_read_b (
    .regs_i (regs_q),
    .addr_i (bus.addr_b),
    .data_o (bus.data_b)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed walk through reset,
// writes, x0 and mid-operation reset, then randomized traffic checked
// against an array model of the architectural registers.
module tb_register_file;

  localparam int W = 64;

  logic clk;
  logic rst_n;

  register_file_if #(.WORDSIZE(W)) bus ();

  register_file #(.WORDSIZE(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Architectural view of the registers, plus bookkeeping
  logic [W-1:0] model [32];
  int checks;
  int failures;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] modelRead(input logic [4:0] addr);
    if (addr == 5'd0) return '0;
    return model[addr];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkReads(input string tag);
    checkOutput({tag, "_a"}, bus.data_a, modelRead(bus.addr_a));
    checkOutput({tag, "_b"}, bus.data_b, modelRead(bus.addr_b));
  endtask

  // One cycle: drive on the falling edge, check old contents before the
  // rising edge, advance the model at the edge, check new contents after it
  task automatic applyStimulus(input logic we, input logic [4:0] wa,
                               input logic [W-1:0] wd, input logic [4:0] aa,
                               input logic [4:0] ab, input string tag);
    @(negedge clk);
    bus.write_en   = we;
    bus.write_addr = wa;
    bus.write_data = wd;
    bus.addr_a     = aa;
    bus.addr_b     = ab;
    #1;
    checkReads({tag, "_pre"});
    @(posedge clk);
    if (rst_n && we && wa != 5'd0) model[wa] = wd;
    #1;
    checkReads({tag, "_post"});
  endtask

  initial begin
    logic [4:0]   wa, aa, ab;
    logic [W-1:0] wd;
    logic         we;

    checks   = 0;
    failures = 0;
    clearModel();
    bus.write_en   = 1'b0;
    bus.write_addr = '0;
    bus.write_data = '0;
    bus.addr_a     = '0;
    bus.addr_b     = '0;

    // Reset, then every address must read zero on both ports
    rst_n = 1'b0;
    #2;
    bus.addr_a = 5'd0;
    bus.addr_b = 5'd2;
    #1;
    checkOutput("rst_a0", bus.data_a, '0);
    checkOutput("rst_b2", bus.data_b, '0);
    for (int i = 0; i < 32; i++) begin
      bus.addr_a = 5'(i);
      bus.addr_b = 5'(31 - i);
      #1;
      checkOutput("rst_all_a", bus.data_a, '0);
      checkOutput("rst_all_b", bus.data_b, '0);
    end

    // Writes are blocked while reset is held
    applyStimulus(1'b1, 5'd9, 64'h1234_5678_9ABC_DEF0, 5'd9, 5'd9, "rst_block");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: basic writes, disabled write, x0 protection
    applyStimulus(1'b1, 5'd4, 64'd5, 5'd4, 5'd7, "wr_x4");
    checkOutput("x4_is_5", bus.data_a, 64'h5);
    applyStimulus(1'b1, 5'd7, 64'd11, 5'd4, 5'd7, "wr_x7");
    checkOutput("x7_is_b", bus.data_b, 64'hB);
    applyStimulus(1'b0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 5'd7, "wr_off");
    checkOutput("x7_kept", bus.data_b, 64'hB);
    applyStimulus(1'b1, 5'd0, 64'hDEAD_BEEF_CAFE_F00D, 5'd0, 5'd0, "wr_x0");
    checkOutput("x0_zero", bus.data_a, '0);
    applyStimulus(1'b0, 5'd0, '0, 5'd7, 5'd7, "same_addr");

    // Asynchronous reset between edges drops both ports without a clock
    @(negedge clk);
    bus.addr_a = 5'd4;
    bus.addr_b = 5'd7;
    #2;
    rst_n = 1'b0;
    clearModel();
    #1;
    checkOutput("async_rst_a", bus.data_a, '0);
    checkOutput("async_rst_b", bus.data_b, '0);
    bus.write_en   = 1'b1;
    bus.write_addr = 5'd31;
    bus.write_data = 64'hA5A5_0000_FFFF_1234;
    bus.addr_a     = 5'd31;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_no_wr", bus.data_a, '0);
    @(posedge clk);
    model[31] = 64'hA5A5_0000_FFFF_1234;
    #1;
    checkOutput("release_wr31", bus.data_a, modelRead(5'd31));
    checkOutput("release_x4", bus.data_b, '0);

    // Randomized traffic, reads often aimed at the write target
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      aa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ab = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      applyStimulus(we, wa, wd, aa, ab, "rand");
    end

    // Final sweep of all registers on both ports
    for (int i = 0; i < 32; i++) begin
      bus.write_en = 1'b0;
      bus.addr_a   = 5'(i);
      bus.addr_b   = 5'(i);
      #1;
      checkReads("sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- RISC-V integer register file for the 64-bit processor datapath: 32 general-purpose registers x0..x31, WORDSIZE bits each.
- Provides two combinational read ports (A and B), used for the rs1/rs2 operands.
- Provides one synchronous write port, used for rd writeback.
- x0 is hardwired to zero.

Parameters:
- WORDSIZE, 64, width in bits of each register and of all data ports.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- write_en  input  1  write enable, sampled at the rising edge of clk.
- write_addr  input  5  destination register index for the write.
- write_data  input  WORDSIZE  value to be written.
- addr_a  input  5  read port A register index.
- addr_b  input  5  read port B register index.
- data_a  output  WORDSIZE  contents of register addr_a.
- data_b  output  WORDSIZE  contents of register addr_b.

Behaviour:
- Storage is 32 entries of WORDSIZE bits.
- Reset: rst_n low clears all 32 registers to 0 immediately, independent of clk.
  - While rst_n is low, data_a and data_b read 0 for every address.
  - Writes are blocked while rst_n is low.
  - A reset asserted mid-operation discards all prior writes.
- Write:
  - At a rising edge of clk with rst_n high and write_en = 1, register[write_addr] takes write_data.
  - Write latency is one edge.
  - With write_en = 0 nothing changes, regardless of write_addr and write_data.
- x0:
  - Writes with write_addr = 0 are silently ignored.
  - register[0] always reads 0.
- Read:
  - Purely combinational, zero latency.
  - data_a = register[addr_a] and data_b = register[addr_b], updating whenever the address or the stored contents change.
  - addr_a = 0 or addr_b = 0 always gives 0.
- Read/write collision: when a read address equals write_addr while write_en = 1, the read port shows the old value before the edge and the new value immediately after it. There is no write-to-read bypass within the same cycle.
- Both read ports may address the same register simultaneously; both return the identical value.
- Data is stored and returned verbatim; no sign or width conversion.
- No X propagation: every register holds a defined value after reset.

Decomposition:
- Shared package holds:
  - XLEN / WORDSIZE default = 64
  - REG_ADDR_W = 5
  - NUM_REGS = 32
  - ZERO_REG = 5'd0
- No sub-module is required. The storage array, write-enable decode and two read multiplexers live in one module.
- Optionally factor the read mux into a reusable reg_read_mux instantiated twice, once per port.

Test Plan:
- Reset then read: pulse rst_n low, then addr_a = 0, addr_b = 2 -> data_a = 0, data_b = 0. Repeat for all 32 addresses -> all read 0.
- Basic write/read: write_en = 1, write_addr = 4, write_data = 5, addr_a = 4, addr_b = 7.
  - Before the rising edge -> data_a = 0.
  - After the edge -> data_a = 0x0000000000000005, data_b = 0.
- Second write: write_addr = 7, write_data = 11, rising edge -> data_a = 0x5, data_b = 0x000000000000000B.
- Write disabled: write_en = 0, write_addr = 7, write_data = 0xFFFF_FFFF_FFFF_FFFF, rising edge -> data_b stays 0xB.
- x0 protection: write_en = 1, write_addr = 0, write_data = 0xDEADBEEF_CAFEF00D, rising edge, addr_a = 0 -> data_a = 0.
- Async reset mid-operation: with x4 = 5 and x7 = 11, drive rst_n low between clock edges -> data_a and data_b drop to 0 at once with no edge. Then release rst_n with write_en = 1 and write_addr = 31 held -> the write takes effect only at the first rising edge after release.
